// File: rtl/bbox_isect_scheduler.sv
// Shares one pipelined ray/AABB intersection unit between NUM_REQ requesters (round-robin).
// Latency: handshake to rsp_valid is ISECT_LAT+2 cycles; issue rate one per cycle.
// Backpressure: req_ready withheld while a requester is busy; responses are never stalled.
//
// Ports:
//   sysclk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready         per-requester handshake (ready is one-hot grant)
//   req_ray_orig/inv_dir/box/range  flattened per-requester operands
//   isect_*                     registered operands to the intersection unit
//   isect_hit/isect_range_out   unit results, ISECT_LAT cycles after operands
//   rsp_valid/rsp_hit/rsp_range routed result (one-hot pulse, shared data)
//   busy, issue_count           per-requester in-flight flags, total handshakes
module bbox_isect_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int ISECT_LAT = 1
) (
  input  logic                   sysclk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*72-1:0]  req_ray_orig,
  input  logic [NUM_REQ*72-1:0]  req_inv_dir,
  input  logic [NUM_REQ*144-1:0] req_box,
  input  logic [NUM_REQ*48-1:0]  req_range,
  output logic [71:0]            isect_ray_orig,
  output logic [71:0]            isect_inv_dir,
  output logic [143:0]           isect_box,
  output logic [47:0]            isect_range,
  input  logic                   isect_hit,
  input  logic [47:0]            isect_range_out,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic                   rsp_hit,
  output logic [47:0]            rsp_range,
  output logic [NUM_REQ-1:0]     busy,
  output logic [31:0]            issue_count
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]    r_ptr;
  logic [NUM_REQ-1:0] r_busy;
  logic [31:0]        r_issue_cnt;
  logic [71:0]        r_ray;
  logic [71:0]        r_inv;
  logic [143:0]       r_box;
  logic [47:0]        r_rng;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic               r_rsp_hit;
  logic [47:0]        r_rsp_range;

  // Tag pipeline: stage k is valid in cycle T+1+k for a handshake at edge T,
  // so the tail stage lines up with the unit's result.
  logic               r_tag_vld [ISECT_LAT+1];
  logic [ID_W-1:0]    r_tag_id  [ISECT_LAT+1];

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_gnt;
  logic [NUM_REQ-1:0] w_clr;
  logic [ID_W-1:0]    w_gnt_id;
  logic               w_hs;
  logic [ID_W:0]      w_sum;
  logic [ID_W-1:0]    w_idx;
  logic               w_tail_vld;
  logic [ID_W-1:0]    w_tail_id;

  assign w_elig     = req_valid & ~r_busy;
  assign w_tail_vld = r_tag_vld[ISECT_LAT];
  assign w_tail_id  = r_tag_id[ISECT_LAT];
  assign w_clr      = w_tail_vld ? (NUM_REQ'(1) << w_tail_id) : '0;

  // Round-robin scan starting at r_ptr; the extra sum bit keeps the modulo
  // wrap exact for non-power-of-two NUM_REQ.
  always_comb begin
    w_hs     = 1'b0;
    w_gnt_id = '0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(NUM_REQ))
        w_idx = ID_W'(w_sum - (ID_W+1)'(NUM_REQ));
      else
        w_idx = ID_W'(w_sum);
      if (!w_hs && w_elig[w_idx]) begin
        w_hs     = 1'b1;
        w_gnt_id = w_idx;
      end
    end
    w_gnt = w_hs ? (NUM_REQ'(1) << w_gnt_id) : '0;
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_busy      <= '0;
      r_issue_cnt <= '0;
      r_ray       <= '0;
      r_inv       <= '0;
      r_box       <= '0;
      r_rng       <= '0;
      r_rsp_valid <= '0;
      r_rsp_hit   <= 1'b0;
      r_rsp_range <= '0;
      for (int k = 0; k <= ISECT_LAT; k++) begin
        r_tag_vld[k] <= 1'b0;
        r_tag_id[k]  <= '0;
      end
    end else begin
      if (w_hs) begin
        r_ray       <= req_ray_orig[w_gnt_id*72 +: 72];
        r_inv       <= req_inv_dir[w_gnt_id*72 +: 72];
        r_box       <= req_box[w_gnt_id*144 +: 144];
        r_rng       <= req_range[w_gnt_id*48 +: 48];
        r_ptr       <= (w_gnt_id == ID_W'(NUM_REQ-1)) ? '0 : w_gnt_id + ID_W'(1);
        r_issue_cnt <= r_issue_cnt + 32'd1;
      end

      r_tag_vld[0] <= w_hs;
      r_tag_id[0]  <= w_gnt_id;
      for (int k = 1; k <= ISECT_LAT; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_id[k]  <= r_tag_id[k-1];
      end

      // Set and clear never hit the same bit: a busy requester cannot be granted.
      r_busy      <= (r_busy & ~w_clr) | w_gnt;
      r_rsp_valid <= w_clr;
      if (w_tail_vld) begin
        r_rsp_hit   <= isect_hit;
        r_rsp_range <= isect_range_out;
      end
    end
  end

  assign req_ready      = w_gnt;
  assign isect_ray_orig = r_ray;
  assign isect_inv_dir  = r_inv;
  assign isect_box      = r_box;
  assign isect_range    = r_rng;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_hit        = r_rsp_hit;
  assign rsp_range      = r_rsp_range;
  assign busy           = r_busy;
  assign issue_count    = r_issue_cnt;

endmodule

// File: tb/tb_bbox_isect_scheduler.sv
// Bench for bbox_isect_scheduler: default instance plus an ISECT_LAT=3 instance.
// Stimulus pushes expected responses into a scoreboard; a monitor pops and compares.
// Intersection units are modelled as fixed-latency functions of their operands.
module tb_bbox_isect_scheduler;
  localparam int N   = 4;
  localparam int LAT = 1;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic              rst;
  logic [N-1:0]      req_valid, req_valid3, req_ready, req_ready3;
  logic [N*72-1:0]   req_ray_orig, req_inv_dir;
  logic [N*144-1:0]  req_box;
  logic [N*48-1:0]   req_range;

  logic [71:0]  isect_ray_orig, isect_inv_dir, isect_ray_orig3, isect_inv_dir3;
  logic [143:0] isect_box, isect_box3;
  logic [47:0]  isect_range, isect_range3, isect_range_out, isect_range_out3;
  logic         isect_hit, isect_hit3;
  logic [N-1:0] rsp_valid, rsp_valid3, busy, busy3;
  logic         rsp_hit, rsp_hit3;
  logic [47:0]  rsp_range, rsp_range3;
  logic [31:0]  issue_count, issue_count3;

  logic [71:0]  t_ray [N];
  logic [71:0]  t_inv [N];
  logic [143:0] t_box [N];
  logic [47:0]  t_rng [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_ray_orig[i*72 +: 72] = t_ray[i];
      req_inv_dir[i*72 +: 72]  = t_inv[i];
      req_box[i*144 +: 144]    = t_box[i];
      req_range[i*48 +: 48]    = t_rng[i];
    end
  end

  bbox_isect_scheduler #(.NUM_REQ(N), .ISECT_LAT(LAT)) dut (
    .sysclk(sysclk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_ray_orig(req_ray_orig), .req_inv_dir(req_inv_dir), .req_box(req_box),
    .req_range(req_range), .isect_ray_orig(isect_ray_orig), .isect_inv_dir(isect_inv_dir),
    .isect_box(isect_box), .isect_range(isect_range), .isect_hit(isect_hit),
    .isect_range_out(isect_range_out), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
    .rsp_range(rsp_range), .busy(busy), .issue_count(issue_count));

  bbox_isect_scheduler #(.NUM_REQ(N), .ISECT_LAT(3)) dut3 (
    .sysclk(sysclk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_ray_orig(req_ray_orig), .req_inv_dir(req_inv_dir), .req_box(req_box),
    .req_range(req_range), .isect_ray_orig(isect_ray_orig3), .isect_inv_dir(isect_inv_dir3),
    .isect_box(isect_box3), .isect_range(isect_range3), .isect_hit(isect_hit3),
    .isect_range_out(isect_range_out3), .rsp_valid(rsp_valid3), .rsp_hit(rsp_hit3),
    .rsp_range(rsp_range3), .busy(busy3), .issue_count(issue_count3));

  function automatic logic f_hit(input logic [71:0] r, input logic [71:0] d,
                                 input logic [143:0] b, input logic [47:0] g);
    return b[0] ^ r[1] ^ d[2] ^ g[3];
  endfunction

  function automatic logic [47:0] f_rng(input logic [71:0] r, input logic [71:0] d,
                                        input logic [143:0] b, input logic [47:0] g);
    return g ^ b[47:0] ^ {r[23:0], d[23:0]};
  endfunction

  // Unit models: 1-cycle and 3-cycle latency.
  always @(posedge sysclk) begin
    isect_hit       <= f_hit(isect_ray_orig, isect_inv_dir, isect_box, isect_range);
    isect_range_out <= f_rng(isect_ray_orig, isect_inv_dir, isect_box, isect_range);
  end

  logic        u3_h [3];
  logic [47:0] u3_r [3];
  always @(posedge sysclk) begin
    u3_h[0] <= f_hit(isect_ray_orig3, isect_inv_dir3, isect_box3, isect_range3);
    u3_r[0] <= f_rng(isect_ray_orig3, isect_inv_dir3, isect_box3, isect_range3);
    u3_h[1] <= u3_h[0];
    u3_r[1] <= u3_r[0];
    u3_h[2] <= u3_h[1];
    u3_r[2] <= u3_r[1];
  end
  assign isect_hit3       = u3_h[2];
  assign isect_range_out3 = u3_r[2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic        hit;
    logic [47:0] rng;
    int          due;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic set_ops(input int i, input logic [7:0] s);
    logic [7:0] d;
    d = s + 8'd17;
    t_ray[i] = {9{s}};
    t_inv[i] = {9{d}};
    t_box[i] = {18{s ^ 8'h3C}};
    t_rng[i] = {16'h0, s, 24'h7FFFFF};
  endtask

  task automatic set_all(input logic [7:0] base);
    for (int i = 0; i < N; i++) set_ops(i, base + 8'(i*7));
  endtask

  task automatic push_exp(input int g);
    exp_t e;
    e.id  = g;
    e.hit = f_hit(t_ray[g], t_inv[g], t_box[g], t_rng[g]);
    e.rng = f_rng(t_ray[g], t_inv[g], t_box[g], t_rng[g]);
    e.due = cyc + LAT + 2;
    sb.push_back(e);
  endtask

  // One cycle: drive valid, check the grant mid-cycle, log expected responses.
  task automatic step(input string nm, input logic [N-1:0] vld,
                      input logic [N-1:0] exp_rdy, input bit do_push);
    req_valid = vld;
    @(negedge sysclk);
    chk(nm, 144'(req_ready), 144'(exp_rdy));
    if (do_push)
      for (int i = 0; i < N; i++) if (exp_rdy[i]) push_exp(i);
    @(posedge sysclk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_valid3 = '0;
    repeat (2) begin @(posedge sysclk); #1; end
    rst = 1'b0;
  endtask

  // Monitor: responses arrive in issue order at a fixed latency.
  initial begin
    exp_t e;
    forever begin
      @(negedge sysclk);
      if (!rst) begin
        if (rsp_valid != '0) begin
          if (sb.size() == 0) begin
            chk("rsp_unexpected", 144'(rsp_valid), 144'(0));
          end else begin
            e = sb.pop_front();
            chk("rsp_id", 144'(rsp_valid), 144'(1) << e.id);
            chk("rsp_hit", 144'(rsp_hit), 144'(e.hit));
            chk("rsp_range", 144'(rsp_range), 144'(e.rng));
            chk("rsp_cycle", 144'(cyc), 144'(e.due));
          end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          chk("rsp_missing", 144'(rsp_valid), 144'(1) << e.id);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_valid3 = '0;
    set_all(8'h10);
    t_box[0] = {24'h0, 24'h0, 24'h0, 24'h001000, 24'h001000, 24'h001000};
    do_reset();

    // Reset state
    chk("reset_rsp_valid", 144'(rsp_valid), 144'(0));
    chk("reset_busy", 144'(busy), 144'(0));
    chk("reset_issue_count", 144'(issue_count), 144'(0));
    chk("reset_isect_box", isect_box, 144'(0));
    chk("reset_isect_range", 144'(isect_range), 144'(0));
    chk("reset_rsp_range", 144'(rsp_range), 144'(0));
    chk("reset_rsp_hit", 144'(rsp_hit), 144'(0));

    // Single request at cycle 5
    for (int c = 0; c < 5; c++) step("t1_idle", 4'b0000, 4'b0000, 1'b1);
    step("t1_grant", 4'b0001, 4'b0001, 1'b1);
    chk("t1_isect_box", isect_box, t_box[0]);
    chk("t1_busy_c6", 144'(busy), 144'(4'b0001));
    step("t1_idle", 4'b0000, 4'b0000, 1'b1);
    chk("t1_busy_c7", 144'(busy), 144'(4'b0001));
    step("t1_idle", 4'b0000, 4'b0000, 1'b1);
    chk("t1_busy_c8", 144'(busy), 144'(4'b0000));
    repeat (3) step("t1_drain", 4'b0000, 4'b0000, 1'b1);

    // Full contention: rotating grants every cycle
    do_reset();
    set_all(8'h40);
    for (int k = 0; k < 8; k++) begin
      if (k == 5) chk("t2_issue_count", 144'(issue_count), 144'(5));
      step("t2_grant", 4'b1111, 4'(1 << (k % 4)), 1'b1);
    end
    chk("t2_issue_count_end", 144'(issue_count), 144'(8));
    repeat (4) step("t2_drain", 4'b0000, 4'b0000, 1'b1);

    // Busy blocking: lone requester 2 every third cycle
    do_reset();
    set_all(8'h70);
    for (int k = 0; k < 9; k++)
      step("t3_busy", 4'b0100, (k % 3 == 0) ? 4'b0100 : 4'b0000, 1'b1);
    repeat (4) step("t3_drain", 4'b0000, 4'b0000, 1'b1);

    // Fairness skip: ptr moved to 1, then requesters 0 and 2 contend
    do_reset();
    set_all(8'hA0);
    step("t4_prime", 4'b0001, 4'b0001, 1'b1);
    repeat (3) step("t4_wait", 4'b0000, 4'b0000, 1'b1);
    set_all(8'hB3);
    for (int k = 0; k < 6; k++)
      step("t4_skip", 4'b0101,
           (k % 3 == 0) ? 4'b0100 : ((k % 3 == 1) ? 4'b0001 : 4'b0000), 1'b1);
    repeat (4) step("t4_drain", 4'b0000, 4'b0000, 1'b1);

    // Reset mid-flight: no response may ever appear
    do_reset();
    set_all(8'hD1);
    step("t5_grant", 4'b0001, 4'b0001, 1'b0);
    rst = 1'b1;
    req_valid = '0;
    @(posedge sysclk); #1;
    rst = 1'b0;
    chk("t5_busy", 144'(busy), 144'(0));
    chk("t5_issue_count", 144'(issue_count), 144'(0));
    for (int c = 2; c <= 10; c++) begin
      @(negedge sysclk);
      chk("t5_no_rsp", 144'(rsp_valid), 144'(0));
      @(posedge sysclk); #1;
    end

    // ISECT_LAT=3 instance: response in cycle 5
    do_reset();
    set_all(8'hC5);
    req_valid3 = 4'b0010;
    @(negedge sysclk);
    chk("t6_ready", 144'(req_ready3), 144'(4'b0010));
    @(posedge sysclk); #1;
    req_valid3 = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge sysclk);
      chk("t6_rsp_valid", 144'(rsp_valid3), (c == 5) ? 144'(4'b0010) : 144'(0));
      if (c == 5) begin
        chk("t6_rsp_hit", 144'(rsp_hit3), 144'(f_hit(t_ray[1], t_inv[1], t_box[1], t_rng[1])));
        chk("t6_rsp_range", 144'(rsp_range3), 144'(f_rng(t_ray[1], t_inv[1], t_box[1], t_rng[1])));
      end
      @(posedge sysclk); #1;
    end

    chk("sb_empty", 144'(sb.size()), 144'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
